// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_rx_pkg;

   typedef enum logic {IDLE, SHIFT} serial_rx_state_t;

   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for asynchronous inputs, with a selectable reset value.
module bit_sync
   import serial_rx_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= {SYNC_STAGES{RST_VAL}};
      end else begin
         stage <= {stage[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/d_shift_left_load.sv
// Shift-left register with synchronous parallel load; load has priority over shift.
module d_shift_left_load #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             shift,
   input  logic             d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= WIDTH'({q, d});
      end
   end

endmodule

// File: rtl/serial_word_rx.sv
// Receives MSB-first framed serial words from an asynchronous shift clock and
// delivers them in the clk domain with valid/pending/overrun/frame-error status.
module serial_word_rx
   import serial_rx_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_clk,
   input  logic             ser_cs_n,
   input  logic             ser_d,
   input  logic             word_ack,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             pending,
   output logic             overrun,
   output logic             frame_err
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic             sclk_sync;
   logic             sclk_dly;
   logic             cs_n_sync;
   logic             d_sync;
   logic             rise_c;
   logic [WIDTH-1:0] sr;
   logic [CNT_W-1:0] cnt;

   serial_rx_state_t state;
   serial_rx_state_t next_state;
   logic             load_c;
   logic             shift_c;
   logic             done_c;
   logic             ferr_c;

   bit_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_sclk_sync (
      .clk (clk), .rst (rst), .d (ser_clk), .q (sclk_sync)
   );

   bit_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_cs_sync (
      .clk (clk), .rst (rst), .d (ser_cs_n), .q (cs_n_sync)
   );

   bit_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_d_sync (
      .clk (clk), .rst (rst), .d (ser_d), .q (d_sync)
   );

   // Edge detect on the synchronized shift clock; d_sync is aligned with rise_c.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_dly <= 1'b0;
      end else begin
         sclk_dly <= sclk_sync;
      end
   end

   assign rise_c = sclk_sync & ~sclk_dly;

   d_shift_left_load #(.WIDTH(WIDTH)) u_sr (
      .clk      (clk),
      .rst      (rst),
      .load     (load_c),
      .load_val ('0),
      .shift    (shift_c),
      .d        (d_sync),
      .q        (sr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Deselect takes priority over a coincident shift edge.
   always_comb begin
      next_state = state;
      load_c     = 1'b0;
      shift_c    = 1'b0;
      done_c     = 1'b0;
      ferr_c     = 1'b0;
      case (state)
         IDLE: begin
            if (!cs_n_sync) begin
               next_state = SHIFT;
               load_c     = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_n_sync) begin
               next_state = IDLE;
               ferr_c     = (cnt != '0);
            end else if (rise_c) begin
               shift_c = 1'b1;
               done_c  = (cnt == CNT_W'(WIDTH - 1));
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Bit counter wraps on word completion so a frame may carry several words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load_c) begin
         cnt <= '0;
      end else if (shift_c) begin
         cnt <= done_c ? '0 : cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word       <= '0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         pending    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         word_valid <= done_c;
         frame_err  <= ferr_c;
         if (done_c) begin
            word <= WIDTH'({sr, d_sync});
         end
         if (done_c) begin
            pending <= 1'b1;
         end else if (word_ack) begin
            pending <= 1'b0;
         end
         // A coincident ack retires the previous word, so no overrun.
         if (done_c && pending && !word_ack) begin
            overrun <= 1'b1;
         end else if (word_ack) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: framing, word delivery, ack handling,
// overrun, short frames and mid-frame reset.
module tb_serial_word_rx;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             ser_clk;
   logic             ser_cs_n;
   logic             ser_d;
   logic             word_ack;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             pending;
   logic             overrun;
   logic             frame_err;

   int vectors     = 0;
   int miscompares = 0;
   int vcount      = 0;
   int fcount      = 0;
   logic [WIDTH-1:0] last_word = '0;

   serial_word_rx #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .ser_clk    (ser_clk),
      .ser_cs_n   (ser_cs_n),
      .ser_d      (ser_d),
      .word_ack   (word_ack),
      .word       (word),
      .word_valid (word_valid),
      .pending    (pending),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (word_valid) begin
            vcount    = vcount + 1;
            last_word = word;
         end
         if (frame_err) fcount = fcount + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ser_bit(input logic b);
      ser_d = b;
      repeat (4) tick();
      ser_clk = 1'b1;
      repeat (4) tick();
      ser_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] data, input int n);
      for (int i = n - 1; i >= 0; i--) ser_bit(data[i]);
   endtask

   task automatic frame_open();
      ser_cs_n = 1'b0;
      repeat (4) tick();
   endtask

   task automatic frame_close();
      repeat (4) tick();
      ser_cs_n = 1'b1;
      repeat (6) tick();
   endtask

   task automatic ack_pulse();
      word_ack = 1'b1;
      tick();
      word_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      ser_clk  = 1'b0;
      ser_cs_n = 1'b1;
      ser_d    = 1'b0;
      word_ack = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      vectors++; if (word !== 8'h00) begin miscompares++; $display("FAIL reset_word: got %h expected 00", word); end
      vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
      vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b expected 0", pending); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
   endtask

   task automatic test_single_word();
      int v0, f0;
      v0 = vcount; f0 = fcount;
      frame_open();
      send_bits(16'h00A5, 8);
      frame_close();
      vectors++; if (vcount - v0 !== 1) begin miscompares++; $display("FAIL single_pulses: got %0d expected 1", vcount - v0); end
      vectors++; if (last_word !== 8'hA5) begin miscompares++; $display("FAIL single_pulse_word: got %h expected a5", last_word); end
      vectors++; if (word !== 8'hA5) begin miscompares++; $display("FAIL single_word: got %h expected a5", word); end
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL single_pending: got %b expected 1", pending); end
      vectors++; if (fcount - f0 !== 0) begin miscompares++; $display("FAIL single_frame_err: got %0d expected 0", fcount - f0); end
      ack_pulse();
      vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL single_ack_pending: got %b expected 0", pending); end
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = vcount;
      frame_open();
      send_bits(16'h003C, 8);
      tick();
      vectors++; if (word !== 8'h3C) begin miscompares++; $display("FAIL b2b_first_word: got %h expected 3c", word); end
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL b2b_first_pending: got %b expected 1", pending); end
      ack_pulse();
      vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL b2b_first_ack: got %b expected 0", pending); end
      send_bits(16'h00C3, 8);
      tick();
      vectors++; if (word !== 8'hC3) begin miscompares++; $display("FAIL b2b_second_word: got %h expected c3", word); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
      ack_pulse();
      frame_close();
      vectors++; if (vcount - v0 !== 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d expected 2", vcount - v0); end
   endtask

   task automatic test_overrun();
      frame_open();
      send_bits(16'h0012, 8);
      tick();
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL ovr_first_pending: got %b expected 1", pending); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_first_overrun: got %b expected 0", overrun); end
      send_bits(16'h0034, 8);
      frame_close();
      vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b expected 1", overrun); end
      vectors++; if (word !== 8'h34) begin miscompares++; $display("FAIL ovr_word: got %h expected 34", word); end
      ack_pulse();
      vectors++; if (pending !== 1'b0) begin miscompares++; $display("FAIL ovr_ack_pending: got %b expected 0", pending); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_ack_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_short_frame();
      int v0, f0;
      v0 = vcount; f0 = fcount;
      frame_open();
      send_bits(16'h0016, 5);
      frame_close();
      vectors++; if (fcount - f0 !== 1) begin miscompares++; $display("FAIL short_frame_err: got %0d expected 1", fcount - f0); end
      vectors++; if (vcount - v0 !== 0) begin miscompares++; $display("FAIL short_valid: got %0d expected 0", vcount - v0); end
      vectors++; if (word !== 8'h34) begin miscompares++; $display("FAIL short_word: got %h expected 34", word); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL short_pulse_end: got %b expected 0", frame_err); end
   endtask

   task automatic test_ack_collision();
      frame_open();
      send_bits(16'h005A, 8);
      frame_close();
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL coll_pre_pending: got %b expected 1", pending); end
      frame_open();
      send_bits(16'h0034, 7);
      ser_d = 1'b1;
      repeat (4) tick();
      ser_clk = 1'b1;
      tick();
      tick();
      word_ack = 1'b1;
      tick();
      vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL coll_valid: got %b expected 1", word_valid); end
      vectors++; if (word !== 8'h69) begin miscompares++; $display("FAIL coll_word: got %h expected 69", word); end
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL coll_pending: got %b expected 1", pending); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL coll_overrun: got %b expected 0", overrun); end
      word_ack = 1'b0;
      tick();
      vectors++; if (pending !== 1'b1) begin miscompares++; $display("FAIL coll_pending_hold: got %b expected 1", pending); end
      vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL coll_valid_pulse: got %b expected 0", word_valid); end
      ser_clk = 1'b0;
      frame_close();
      ack_pulse();
   endtask

   task automatic test_reset_midframe();
      int v0, f0;
      frame_open();
      send_bits(16'h000F, 4);
      rst = 1'b1;
      #1;
      vectors++; if (word !== 8'h00) begin miscompares++; $display("FAIL mid_rst_word: got %h expected 00", word); end
      vectors++; if (pending !== 1'b0 || overrun !== 1'b0 || word_valid !== 1'b0 || frame_err !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_rst_flags: got p=%b o=%b v=%b f=%b expected all 0", pending, overrun, word_valid, frame_err);
      end
      tick();
      ser_cs_n = 1'b1;
      tick();
      rst = 1'b0;
      repeat (4) tick();
      v0 = vcount; f0 = fcount;
      frame_open();
      send_bits(16'h0081, 8);
      frame_close();
      vectors++; if (word !== 8'h81) begin miscompares++; $display("FAIL mid_word: got %h expected 81", word); end
      vectors++; if (vcount - v0 !== 1) begin miscompares++; $display("FAIL mid_pulses: got %0d expected 1", vcount - v0); end
      vectors++; if (fcount - f0 !== 0) begin miscompares++; $display("FAIL mid_frame_err: got %0d expected 0", fcount - f0); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overrun();
      test_short_frame();
      test_ack_collision();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver: accepts an MSB-first bit stream framed by an active-low select and clocked by an external, asynchronous shift clock. It assembles `WIDTH`-bit words in the `clk` domain and presents each one with a single-cycle valid strobe. It is the receiving end of the parallel-load, shift-left serializer link used between FPGA blocks and off-chip peripherals. It flags short frames and unacknowledged-word overruns.

## Interface
- `WIDTH`, 8: bits per word; must be ≥ 2.
- `clk`  in  1  system clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ser_clk`  in  1  external shift clock, asynchronous to `clk`; data sampled on its rising edge.
- `ser_cs_n`  in  1  frame select, active low, asynchronous.
- `ser_d`  in  1  serial data, MSB first, asynchronous.
- `word_ack`  in  1  consumer acknowledge; clears `pending` and `overrun`.
- `word`  out  WIDTH  last complete word; held until the next word completes.
- `word_valid`  out  1  one-cycle pulse when `word` updates.
- `pending`  out  1  word delivered and not yet acknowledged.
- `overrun`  out  1  sticky; a word completed while `pending` was set.
- `frame_err`  out  1  one-cycle pulse on a short frame.

## Operation
- Reset values:
  - `word`=0, `word_valid`=0, `pending`=0, `overrun`=0, `frame_err`=0.
  - Shift register and bit counter = 0; FSM in IDLE.
  - Synchronizers: `ser_cs_n` chain resets to 1; `ser_clk` and `ser_d` chains reset to 0.
- Synchronization: all three inputs pass through 2-FF synchronizers. A third register on `ser_clk` gives `rise = s2 & ~s3`. `ser_d` uses the same depth, so sampled data is aligned with `rise`.
- FSM states: IDLE and SHIFT.
  - IDLE → SHIFT when synchronized `cs_n`=0. The bit counter and shift register clear on entry.
  - SHIFT → IDLE when synchronized `cs_n`=1.
- In SHIFT, on `rise`:
  - Shift register ← {sr[WIDTH-2:0], d_sync}.
  - Bit counter increments.
- Word completion: when `rise` occurs with counter = WIDTH-1:
  - `word` ← {sr[WIDTH-2:0], d_sync} and `word_valid` pulses.
  - The counter wraps to 0, so back-to-back words within one frame are supported.
- Short frame: on SHIFT → IDLE with counter ≠ 0, `frame_err` pulses once. The partial word is discarded and `word` is unchanged. SHIFT → IDLE with counter = 0 is a clean end of frame.
- Simultaneous events:
  - `rise` in the same cycle that synchronized `cs_n` goes high: the edge is ignored. Deselect wins.
  - `rise` in IDLE is ignored.
  - `word_valid` and `word_ack` in the same cycle: `pending` stays 1 for the new word and `overrun` is not set.
  - `word_valid` with `pending`=1 and no ack: `overrun` ← 1. It stays set until `word_ack`.
- `word_ack` with `pending`=0 is harmless and clears `overrun`.
- Reset mid-frame: everything returns to reset values immediately. The next frame needs a fresh `cs_n` falling edge as seen through the synchronizer.

## Timing
- Input constraints:
  - `ser_clk` high and low phases each ≥ 3 `clk` periods.
  - `ser_d` stable from ≥ 2 `clk` periods before to ≥ 2 after each `ser_clk` rise.
  - `ser_cs_n` falls ≥ 3 `clk` periods before the first `ser_clk` rise.
- Latency: a `ser_clk` rise first captured by s1 at clk edge k gives `word`/`word_valid` registered at edge k+2, with the pulse high for one period.
- `frame_err`: registered 2 edges after s1 first captures `ser_cs_n` = 1.
- `pending` and `overrun` update in the same cycle `word_valid` goes high. `word_ack` takes effect at the next clk edge.
- Maximum word rate: one word per WIDTH × 6 `clk` periods.

## Structure
- Package `serial_rx_pkg`:
  - `typedef enum logic {IDLE, SHIFT} serial_rx_state_t`.
  - `localparam SYNC_STAGES = 2`.
- Sub-module `bit_sync #(WIDTH, RST_VAL)`: 2-FF synchronizer with asynchronous reset to `RST_VAL`. Instantiated for `ser_clk`, `ser_cs_n` and `ser_d`.
- The shift register reuses the existing `d_shift_left_load`. Its load input clears it on entry to SHIFT.
- The bit counter is $clog2(WIDTH) bits wide.

## Test plan
- Reset, then frame 0xA5 with 8 edges and `cs_n` released: `word`=0xA5, one `word_valid` pulse, `pending`=1, no `frame_err`.
- One frame of 16 edges carrying 0x3C then 0xC3, with `word_ack` after each: two pulses, `word`=0x3C then 0xC3, `overrun`=0.
- Two words with no ack: second pulse sets `overrun`=1 and `word`=2nd value. `word_ack` clears both `pending` and `overrun`.
- Frame of 5 edges, then `cs_n` high: `frame_err` pulses once, `word` keeps its prior value, no `word_valid`.
- `word_ack` asserted in the same cycle as `word_valid`: `pending` stays 1, `overrun` stays 0.
- `rst` after 4 bits of a frame, then full frame 0x81: all outputs zero after reset, then `word`=0x81 with no stale bits.
